// File: rtl/adc_collect_pkg.sv
// adc_collect_pkg: shared constants and word packing for the ADC result collector
package adc_collect_pkg;
    localparam int RESULT_W = 40;
    localparam int ID_W = 8;
    localparam logic [3:0] TAG = 4'hA;
    localparam logic [11:0] SAT_COUNT = 12'hFFF;
    localparam int ID_MSB = 63;
    localparam int ID_LSB = 56;
    localparam int CH_MSB = 55;
    localparam int CH_LSB = 52;
    localparam int TAG_MSB = 51;
    localparam int TAG_LSB = 48;
    localparam int SAT_BIT = 40;
    localparam int RES_MSB = 39;
    localparam int RES_LSB = 0;
    localparam int CNT_MSB = 39;
    localparam int CNT_LSB = 28;

    function automatic logic [63:0] make_word(input logic [ID_W-1:0] id, input logic [3:0] ch,
                                              input logic [RESULT_W-1:0] res);
        logic [63:0] w;
        w = '0;
        w[ID_MSB:ID_LSB] = id;
        w[CH_MSB:CH_LSB] = ch;
        w[TAG_MSB:TAG_LSB] = TAG;
        w[SAT_BIT] = res[CNT_MSB:CNT_LSB] == SAT_COUNT;
        w[RES_MSB:RES_LSB] = res;
        return w;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter, search starts one past the last winner
module rr_arbiter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant,
    output logic [3:0]   grant_idx
);
    logic [3:0] last_q;
    logic       found;

    // Requesters above the last winner take priority, then the lowest index wraps around
    always_comb begin
        found = 1'b0;
        grant_idx = 4'd0;
        grant = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && 4'(i) > last_q) begin
                found = 1'b1;
                grant_idx = 4'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                grant_idx = 4'(i);
            end
        end
        for (int i = 0; i < N; i++) grant[i] = en && found && grant_idx == 4'(i);
    end

    // Remember the winner so the next search starts after it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= 4'(N - 1);
        else if (en && found) last_q <= grant_idx;
    end
endmodule

// File: rtl/adc_result_collector.sv
// adc_result_collector: captures per-channel ADC results and streams them as tagged 64-bit words
module adc_result_collector
    import adc_collect_pkg::*;
#(
    parameter int N_CHANNELS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [RESULT_W*N_CHANNELS-1:0] result_in,
    input  logic [N_CHANNELS-1:0]          result_ready_in,
    input  logic [ID_W*N_CHANNELS-1:0]     counter_id_in,
    output logic [N_CHANNELS-1:0]          result_ack,
    output logic [63:0]                    out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [15:0]                    drop_count,
    input  logic                           drop_clear
);
    localparam int N = N_CHANNELS;

    logic [RESULT_W-1:0] res_q [N];
    logic [ID_W-1:0]     id_q  [N];
    logic [N-1:0]        full_q, rr_q, ack_q, grant;
    logic [3:0]          grant_idx;
    logic [63:0]         out_data_q, word_d;
    logic [15:0]         drop_q, drop_d;
    logic                out_valid_q, grant_en, drop_any;

    assign result_ack = result_ready_in & ~full_q;
    assign grant_en = ~out_valid_q | out_ready;
    assign out_data = out_data_q;
    assign out_valid = out_valid_q;
    assign drop_count = drop_q;

    rr_arbiter #(.N(N)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (full_q),
        .en       (grant_en),
        .grant    (grant),
        .grant_idx(grant_idx)
    );

    // Pack the winning slot; a drop is a ready that fell without ever being acked
    always_comb begin
        word_d = '0;
        for (int i = 0; i < N; i++) if (grant[i]) word_d = make_word(id_q[i], grant_idx, res_q[i]);
        drop_any = |(rr_q & ~result_ready_in & ~ack_q);
        drop_d = drop_clear ? 16'd0 : (drop_any && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end

    // Capture only into empty slots; a granted slot frees at the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= '0;
            for (int i = 0; i < N; i++) begin
                res_q[i] <= '0;
                id_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (result_ack[i]) begin
                    res_q[i] <= result_in[RESULT_W*i +: RESULT_W];
                    id_q[i] <= counter_id_in[ID_W*i +: ID_W];
                    full_q[i] <= 1'b1;
                end else if (grant[i]) begin
                    full_q[i] <= 1'b0;
                end
            end
        end
    end

    // Output register loads a new word whenever it is empty or being accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q <= '0;
        end else if (|grant) begin
            out_valid_q <= 1'b1;
            out_data_q <= word_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Delayed ready/ack for drop detection and the saturating drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= '0;
            ack_q <= '0;
            drop_q <= '0;
        end else begin
            rr_q <= result_ready_in;
            ack_q <= result_ack;
            drop_q <= drop_d;
        end
    end
endmodule

// File: tb/tb_adc_result_collector.sv
// tb_adc_result_collector: scoreboard bench with directed and randomized stimulus
module tb_adc_result_collector;
    localparam int N = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [40*N-1:0] result_in = '0;
    logic [N-1:0]    result_ready_in = '0;
    logic [8*N-1:0]  counter_id_in = '0;
    logic [N-1:0]    result_ack;
    logic [63:0]     out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [15:0]     drop_count;
    logic            drop_clear = 1'b0;

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q [N][$];
    int ch_log[$];

    adc_result_collector #(.N_CHANNELS(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .result_in      (result_in),
        .result_ready_in(result_ready_in),
        .counter_id_in  (counter_id_in),
        .result_ack     (result_ack),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .drop_count     (drop_count),
        .drop_clear     (drop_clear)
    );

    always #5 clk = ~clk;

    // Expected word straight from the field layout
    function automatic logic [63:0] exp_word(int ch, logic [7:0] id, logic [39:0] r);
        return {id, 4'(ch), 4'hA, 7'd0, r[39:28] == 12'hFFF, r};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ch(int ch, logic [7:0] id, logic [39:0] r);
        counter_id_in[8*ch +: 8] = id;
        result_in[40*ch +: 40] = r;
    endtask

    task automatic rand_data(logic [N-1:0] m);
        logic [39:0] r;
        for (int i = 0; i < N; i++) begin
            if (m[i]) begin
                r = {8'($urandom), 32'($urandom)};
                if ($urandom % 8 == 0) r[39:28] = 12'hFFF;
                set_ch(i, 8'($urandom), r);
            end
        end
    endtask

    task automatic push_exp(logic [N-1:0] m);
        for (int i = 0; i < N; i++)
            if (m[i]) exp_q[i].push_back(exp_word(i, counter_id_in[8*i +: 8], result_in[40*i +: 40]));
    endtask

    // One-cycle ready pulse; enters and leaves at posedge+1
    task automatic pulse(logic [N-1:0] m, bit acked);
        result_ready_in = m;
        if (acked) push_exp(m);
        @(negedge clk);
        check("pulse_ack", result_ack & m, acked ? m : '0);
        @(posedge clk);
        #1;
        result_ready_in = '0;
    endtask

    // Single pulse with out_ready high: word visible exactly at T+2 for one cycle
    task automatic single(int ch, logic [7:0] id, logic [39:0] r, logic [63:0] lit);
        set_ch(ch, id, r);
        pulse(N'(1) << ch, 1'b1);
        @(negedge clk);
        check("lat_t1_valid", out_valid, 0);
        @(negedge clk);
        check("lat_t2_valid", out_valid, 1);
        check("lat_t2_data", out_data, lit);
        @(negedge clk);
        check("lat_t3_valid", out_valid, 0);
        @(posedge clk);
        #1;
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += exp_q[i].size();
        return s;
    endfunction

    // Monitor: pops the channel's expected queue on every accepted word, checks hold stability
    logic        hold = 1'b0;
    logic [63:0] held = '0;
    int          mch;
    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, held);
            end
            if (out_valid && out_ready) begin
                mch = int'(out_data[55:52]);
                ch_log.push_back(mch);
                if (mch >= N || exp_q[mch].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got %h expected none", out_data);
                end else begin
                    check("word", out_data, exp_q[mch].pop_front());
                end
            end
            hold = out_valid && !out_ready;
            held = out_data;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] m;
        int w;
        // Reset values, ack mirrors ready while slots are cleared
        result_ready_in = 8'h05;
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_drop", drop_count, 0);
        check("rst_ack", result_ack, 8'h05);
        result_ready_in = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(2);

        // Fairness from reset: 0,1,3 then 0,3
        out_ready = 1'b1;
        rand_data(8'b1011);
        ch_log.delete();
        pulse(8'b1011, 1'b1);
        cyc(6);
        check("fair1_n", ch_log.size(), 3);
        if (ch_log.size() == 3) begin
            check("fair1_0", ch_log[0], 0);
            check("fair1_1", ch_log[1], 1);
            check("fair1_2", ch_log[2], 3);
        end
        rand_data(8'b1001);
        ch_log.delete();
        pulse(8'b1001, 1'b1);
        cyc(6);
        check("fair2_n", ch_log.size(), 2);
        if (ch_log.size() == 2) begin
            check("fair2_0", ch_log[0], 0);
            check("fair2_1", ch_log[1], 3);
        end

        // Single pulse on channel 2
        single(2, 8'h17, 40'h003_0000123, 64'h172A_0000_3000_0123);

        // Backpressure hold then drain without duplication
        out_ready = 1'b0;
        rand_data(8'h10);
        pulse(8'h10, 1'b1);
        cyc(2);
        check("bp_valid", out_valid, 1);
        rand_data(8'h60);
        pulse(8'h60, 1'b1);
        cyc(10);
        out_ready = 1'b1;
        cyc(8);
        check("bp_drain", pending(), 0);

        // Drop: slot 1 full, second pulse not acked
        out_ready = 1'b0;
        rand_data(8'h80);
        pulse(8'h80, 1'b1);
        cyc(2);
        rand_data(8'h02);
        pulse(8'h02, 1'b1);
        cyc(4);
        rand_data(8'h02);
        pulse(8'h02, 1'b0);
        cyc(3);
        check("drop_one", drop_count, 1);
        drop_clear = 1'b1;
        cyc(1);
        drop_clear = 1'b0;
        check("drop_clear", drop_count, 0);

        // Saturation: alternate two blocked channels for one drop per cycle
        rand_data(8'h04);
        pulse(8'h04, 1'b1);
        for (int k = 0; k < 65545; k++) begin
            if (k == 100) check("drop_mid", drop_count, 99);
            result_ready_in = k[0] ? 8'h04 : 8'h02;
            cyc(1);
        end
        result_ready_in = '0;
        cyc(2);
        check("drop_sat", drop_count, 16'hFFFF);
        result_ready_in = 8'h02;
        cyc(1);
        result_ready_in = '0;
        cyc(2);
        check("drop_sat_hold", drop_count, 16'hFFFF);

        // Reset mid-operation with three slots full and a word held
        rand_data(8'h08);
        pulse(8'h08, 1'b1);
        check("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_drop", drop_count, 0);
        for (int i = 0; i < N; i++) exp_q[i].delete();
        cyc(2);
        rst = 1'b0;
        cyc(1);
        out_ready = 1'b1;
        single(0, 8'h3C, 40'hFFF_0000001, 64'h3C0A_01FF_F000_0001);

        // Randomized traffic: pulse only channels with nothing outstanding
        for (int c = 0; c < 600; c++) begin
            out_ready = ($urandom % 4) != 0;
            m = '0;
            for (int i = 0; i < N; i++) if (exp_q[i].size() == 0 && $urandom % 3 == 0) m[i] = 1'b1;
            rand_data(m);
            result_ready_in = m;
            push_exp(m);
            @(negedge clk);
            check("rand_ack", result_ack, m);
            @(posedge clk);
            #1;
        end
        result_ready_in = '0;
        out_ready = 1'b1;
        w = 0;
        while (pending() != 0 && w < 200) begin
            cyc(1);
            w++;
        end
        check("rand_drain", pending(), 0);
        check("rand_drop", drop_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
